mul_sequencer: RTL

- Iterative shift-add multiplier that executes the custom MUL instruction (opcode 7'b1111111) flagged by the main controller's `mul` control bit.
- Sits downstream of the main controller, beside the ALU.
- Takes rs1/rs2 from the register file and holds the processor with `stall` while it computes.
- Presents the product on the writeback path for exactly one cycle.

---
 rtl/mul_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative shift-add unsigned multiplier for the custom MUL
// instruction. Accepts operands in IDLE, iterates WIDTH cycles in BUSY and
// presents the 2*WIDTH-bit product with a one-cycle result_valid in DONE.
module mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mul_en,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               last_iter;

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // Partial-product add for the current iteration; carry out of 2*WIDTH is dropped.
    always_comb begin
        acc_sum = acc + (mplier[0] ? mcand : '0);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: DONE always returns to IDLE without sampling mul_en.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (mul_en) state_next = BUSY;
            BUSY:    if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: stall is combinational on mul_en in IDLE so the PC holds immediately.
    always_comb begin
        stall        = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        unique case (state)
            IDLE:    stall = mul_en;
            BUSY:    begin
                stall = 1'b1;
                busy  = 1'b1;
            end
            DONE:    result_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, shift-add iteration, counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            if (state == IDLE && mul_en) begin
                mcand  <= {{WIDTH{1'b0}}, op_a};
                mplier <= op_b;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == BUSY) begin
                acc    <= acc_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
            end
        end
    end

    // Result registers load the final sum on the last BUSY edge so they are
    // valid during DONE, then hold until the next product completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_lo <= '0;
            result_hi <= '0;
        end else if (state == BUSY && last_iter) begin
            result_lo <= acc_sum[WIDTH-1:0];
            result_hi <= acc_sum[2*WIDTH-1:WIDTH];
        end
    end

endmodule
